shift_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 32-bit logical right shifter in the ALU.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- Width is configurable. The shift is split into one registered stage per shift-amount bit.
- Has a valid/ready handshake on both ends, so it sits between the operand-issue logic and the ALU result mux and tolerates result back-pressure.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_stage.sv | 70 +++++++
 rtl/shift_unit_pipe.sv | 92 +++++++++
 tb/tb_shift_unit_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shift unit.
package shift_pkg;

  // Operation select; every encoding is a legal operation.
  typedef enum logic [1:0] {
    SH_SRL = 2'b00,
    SH_SRA = 2'b01,
    SH_SLL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

  localparam int unsigned MODE_W = 2;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift/rotate by 2^K, then a register that
// advances on i_en and clears synchronously on i_rst.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = $clog2(WIDTH),
  parameter int unsigned K     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  shift_mode_e      i_mode,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_sign,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output shift_mode_e      o_mode,
  output logic [AMT_W-1:0] o_amt,
  output logic             o_sign
);

  localparam int unsigned D = 1 << K;

  logic [WIDTH-1:0] w_shifted;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  shift_mode_e      r_mode;
  logic [AMT_W-1:0] r_amt;
  logic             r_sign;

  // Shift or rotate by D when this stage's amount bit is set.
  always_comb begin
    w_shifted = i_data;
    if (i_amt[K]) begin
      unique case (i_mode)
        SH_SRL: w_shifted = {{D{1'b0}}, i_data[WIDTH-1:D]};
        SH_SRA: w_shifted = {{D{i_sign}}, i_data[WIDTH-1:D]};
        SH_SLL: w_shifted = {i_data[WIDTH-1-D:0], {D{1'b0}}};
        SH_ROR: w_shifted = {i_data[D-1:0], i_data[WIDTH-1:D]};
      endcase
    end
  end

  // Stage register; bubbles carry zero data so c_o reads 0 when nothing is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= SH_SRL;
      r_amt   <= '0;
      r_sign  <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? w_shifted : '0;
      r_mode  <= i_mode;
      r_amt   <= i_amt;
      r_sign  <= i_sign;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_amt   = r_amt;
  assign o_sign  = r_sign;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined shifter/rotator: one registered stage per shift-amount bit,
// valid/ready on both ends, whole pipe stalls together under back-pressure.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] b_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] c_o,
  output logic             busy_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    shift_mode_e      mode;
    logic [AMT_W-1:0] amt;
    logic             sign;
    logic             valid;
  } payload_t;

  payload_t w_head;
  payload_t w_stage_q [AMT_W];
  logic     w_adv;
  logic     w_unused_tail;

  // Last stage doubles as the output register, so it alone gates advance.
  assign w_adv   = ~w_stage_q[AMT_W-1].valid | ready_i;
  assign ready_o = w_adv;

  // Pack the incoming operand into the stage payload.
  always_comb begin
    w_head.data  = a_i;
    w_head.mode  = shift_mode_e'(mode_i);
    w_head.amt   = b_i;
    w_head.sign  = a_i[WIDTH-1];
    w_head.valid = valid_i & w_adv;
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    payload_t w_in;
    if (k == 0) begin : g_first
      assign w_in = w_head;
    end else begin : g_chain
      assign w_in = w_stage_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W),
      .K     (k)
    ) u_stage (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_en    (w_adv),
      .i_valid (w_in.valid),
      .i_data  (w_in.data),
      .i_mode  (w_in.mode),
      .i_amt   (w_in.amt),
      .i_sign  (w_in.sign),
      .o_valid (w_stage_q[k].valid),
      .o_data  (w_stage_q[k].data),
      .o_mode  (w_stage_q[k].mode),
      .o_amt   (w_stage_q[k].amt),
      .o_sign  (w_stage_q[k].sign)
    );
  end

  // Busy whenever any stage, including the output stage, holds an operation.
  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < AMT_W; k++) begin
      busy_o = busy_o | w_stage_q[k].valid;
    end
  end

  assign valid_o = w_stage_q[AMT_W-1].valid;
  assign c_o     = w_stage_q[AMT_W-1].data;

  // Control fields are dead once the last stage has been applied.
  assign w_unused_tail = ^{w_stage_q[AMT_W-1].mode, w_stage_q[AMT_W-1].amt,
                           w_stage_q[AMT_W-1].sign};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: WIDTH=32 main instance with a scoreboard, plus
// WIDTH=8 and WIDTH=64 instances for latency and SRA/ROR checks.
module tb_shift_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main DUT, WIDTH=32
  logic        rst, v_i, rdy_o, v_o, rdy_i, busy;
  logic [31:0] a, c;
  logic [4:0]  b;
  logic [1:0]  m;

  // WIDTH=8 instance
  logic        v8_i, rdy8_o, v8_o, busy8;
  logic [7:0]  a8, c8;
  logic [2:0]  b8;
  logic [1:0]  m8;

  // WIDTH=64 instance
  logic        v64_i, rdy64_o, v64_o, busy64;
  logic [63:0] a64, c64;
  logic [5:0]  b64;
  logic [1:0]  m64;

  shift_unit_pipe #(.WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(v_i), .ready_o(rdy_o), .a_i(a), .b_i(b),
    .mode_i(m), .valid_o(v_o), .ready_i(rdy_i), .c_o(c), .busy_o(busy)
  );

  shift_unit_pipe #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8_i), .ready_o(rdy8_o), .a_i(a8), .b_i(b8),
    .mode_i(m8), .valid_o(v8_o), .ready_i(1'b1), .c_o(c8), .busy_o(busy8)
  );

  shift_unit_pipe #(.WIDTH(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .valid_i(v64_i), .ready_o(rdy64_o), .a_i(a64), .b_i(b64),
    .mode_i(m64), .valid_o(v64_o), .ready_i(1'b1), .c_o(c64), .busy_o(busy64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of each mode.
  function automatic logic [63:0] ref_shift(input logic [63:0] av, input int n,
                                            input logic [1:0] mode, input int w);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = av & mask;
    case (mode)
      2'b00:   r = x >> n;
      2'b01:   r = (x >> n) | (x[w-1] ? (mask & ~(mask >> n)) : 64'd0);
      2'b10:   r = (x << n) & mask;
      default: r = ((x >> n) | (x << (w - n))) & mask;
    endcase
    return r;
  endfunction

  // Scoreboard and per-cycle protocol checks for the 32-bit instance.
  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic        prev_rst   = 1'b1;
  logic [31:0] prev_c     = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    chk("ready_o", 64'(rdy_o), 64'(!v_o || rdy_i));
    chk("busy_o", 64'(busy), 64'(exp_q.size() != 0));
    if (!prev_rst && prev_stall) begin
      chk("stall valid_o", 64'(v_o), 64'd1);
      chk("stall c_o", 64'(c), 64'(prev_c));
    end
    if (v_o && exp_q.size() == 0) chk("spurious valid_o", 64'(v_o), 64'd0);
    if (v_o && rdy_i && exp_q.size() != 0) chk("result c_o", 64'(c), 64'(exp_q.pop_front()));
    if (rst) begin
      exp_q.delete();
    end else if (v_i && rdy_o) begin
      e = ref_shift(64'(a), int'(b), m, 32);
      exp_q.push_back(e[31:0]);
    end
    prev_stall = v_o && !rdy_i;
    prev_rst   = rst;
    prev_c     = c;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single op on the 32-bit DUT with latency and literal result check.
  task automatic op32(input string name, input logic [31:0] av, input logic [4:0] n,
                      input logic [1:0] mode, input logic [31:0] exp);
    int lat;
    v_i = 1'b1; a = av; b = n; m = mode; rdy_i = 1'b1;
    step();
    v_i = 1'b0;
    lat = 1;
    while (!v_o && lat < 20) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd5);
    chk(name, 64'(c), 64'(exp));
    step();
  endtask

  task automatic op8(input string name, input logic [7:0] av, input logic [2:0] n,
                     input logic [1:0] mode, input logic [7:0] exp);
    int lat;
    v8_i = 1'b1; a8 = av; b8 = n; m8 = mode;
    step();
    v8_i = 1'b0;
    lat = 1;
    while (!v8_o && lat < 20) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd3);
    chk(name, 64'(c8), 64'(exp));
    step();
  endtask

  task automatic op64(input string name, input logic [63:0] av, input logic [5:0] n,
                      input logic [1:0] mode, input logic [63:0] exp);
    int lat;
    v64_i = 1'b1; a64 = av; b64 = n; m64 = mode;
    step();
    v64_i = 1'b0;
    lat = 1;
    while (!v64_o && lat < 20) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd6);
    chk(name, c64, exp);
    step();
  endtask

  task automatic rand32();
    a = $urandom;
    b = 5'($urandom_range(31));
    m = 2'($urandom_range(3));
  endtask

  initial begin
    logic [63:0] r;
    int waited;
    rst = 1'b1; v_i = 1'b1; rdy_i = 1'b1; a = 32'hDEAD_BEEF; b = 5'd3; m = 2'b01;
    v8_i = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    v64_i = 1'b0; a64 = '0; b64 = '0; m64 = '0;
    repeat (3) step();
    rst = 1'b0; v_i = 1'b0;

    // Reset state; valid_i during reset must have been dropped
    chk("reset valid_o", 64'(v_o), 64'd0);
    chk("reset busy_o", 64'(busy), 64'd0);
    chk("reset ready_o", 64'(rdy_o), 64'd1);
    chk("reset c_o", 64'(c), 64'd0);
    step();
    chk("idle valid_o", 64'(v_o), 64'd0);
    chk("idle c_o", 64'(c), 64'd0);

    // Single ops
    op32("SRL n=4", 32'h8000_00F1, 5'd4, 2'b00, 32'h0800_000F);
    op32("SRA n=4", 32'h8000_00F1, 5'd4, 2'b01, 32'hF800_000F);
    op32("SLL n=4", 32'h8000_00F1, 5'd4, 2'b10, 32'h0000_0F10);
    op32("ROR n=4", 32'h8000_00F1, 5'd4, 2'b11, 32'h1800_000F);

    // Boundaries
    op32("SRL n=31", 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h0000_0001);
    op32("SRA n=31", 32'hFFFF_FFFF, 5'd31, 2'b01, 32'hFFFF_FFFF);
    op32("SLL n=31", 32'hFFFF_FFFF, 5'd31, 2'b10, 32'h8000_0000);
    op32("ROR n=31", 32'h8000_00F1, 5'd31, 2'b11, 32'h0000_01E3);
    op32("SRA n=31 pos", 32'h7FFF_FFFF, 5'd31, 2'b01, 32'h0000_0000);
    for (int k = 0; k < 4; k++) op32("n=0", 32'hFFFF_FFFF, 5'd0, 2'(k), 32'hFFFF_FFFF);

    // Back-to-back stream: results on consecutive cycles, latency 5
    for (int t = 0; t < 30; t++) begin
      v_i = (t < 20);
      rand32();
      @(negedge clk);
      chk("stream valid_o", 64'(v_o), 64'((t >= 5) && (t < 25)));
      @(posedge clk);
      #1;
    end
    v_i = 1'b0;

    // Back-pressure with a full pipe
    for (int t = 0; t < 8; t++) begin
      v_i = 1'b1; rdy_i = 1'b1; rand32();
      step();
    end
    rdy_i = 1'b0;
    for (int t = 0; t < 7; t++) begin
      rand32();
      @(negedge clk);
      chk("stall ready_o", 64'(rdy_o), 64'd0);
      @(posedge clk);
      #1;
    end
    rdy_i = 1'b1;
    for (int t = 0; t < 5; t++) begin
      rand32();
      step();
    end
    v_i = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      step();
      waited++;
    end
    chk("drain after stall", 64'(exp_q.size()), 64'd0);

    // Random valid/ready traffic
    for (int t = 0; t < 400; t++) begin
      v_i = 1'($urandom_range(1));
      rdy_i = ($urandom_range(3) != 0);
      rand32();
      step();
    end
    v_i = 1'b0; rdy_i = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      step();
      waited++;
    end
    chk("drain after random", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight: three ops, reset on the 2nd cycle after the last issue
    for (int t = 0; t < 3; t++) begin
      v_i = 1'b1; rand32();
      step();
    end
    v_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-reset busy_o", 64'(busy), 64'd0);
    chk("post-reset valid_o", 64'(v_o), 64'd0);
    repeat (10) step();

    // Narrow and wide instances
    op8("W8 SRA n=3", 8'h96, 3'd3, 2'b01, 8'hF2);
    op8("W8 ROR n=3", 8'h96, 3'd3, 2'b11, 8'hD2);
    op64("W64 SRA n=63", 64'h8000_0000_0000_0001, 6'd63, 2'b01, '1);
    op64("W64 ROR n=63", 64'h8000_0000_0000_0001, 6'd63, 2'b11, 64'h3);
    for (int k = 0; k < 4; k++) begin
      logic [7:0]  ra8;
      logic [2:0]  rn8;
      logic [63:0] ra64;
      logic [5:0]  rn64;
      logic [1:0]  md;
      md   = (k[0]) ? 2'b11 : 2'b01;
      ra8  = 8'($urandom);
      rn8  = 3'($urandom_range(7));
      r    = ref_shift(64'(ra8), int'(rn8), md, 8);
      op8("W8 random", ra8, rn8, md, r[7:0]);
      ra64 = {$urandom, $urandom};
      rn64 = 6'($urandom_range(63));
      r    = ref_shift(ra64, int'(rn64), md, 64);
      op64("W64 random", ra64, rn64, md, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
